// File: rtl/ctrl_regs_pkg.sv
// ctrl_regs_pkg: shared offsets, AXI encodings, channel structs and FSM states for axi_ctrl_responder.
package ctrl_regs_pkg;
    localparam int unsigned IdW      = 6;
    localparam int unsigned AddrW    = 32;
    localparam int unsigned AxiDataW = 128;
    localparam int unsigned RegW     = 32;

    localparam int unsigned EocOffset      = 'h00;
    localparam int unsigned WakeUpOffset   = 'h04;
    localparam int unsigned Scratch0Offset = 'h08;
    localparam int unsigned Scratch1Offset = 'h0C;
    localparam int unsigned NumCoresOffset = 'h10;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {IDLE, WRITE, WRITE_RESP, READ} ctrl_state_e;

    typedef struct packed {
        logic [IdW-1:0]        aw_id;
        logic [AddrW-1:0]      aw_addr;
        logic [7:0]            aw_len;
        logic [2:0]            aw_size;
        logic [1:0]            aw_burst;
        logic                  aw_valid;
        logic [AxiDataW-1:0]   w_data;
        logic [AxiDataW/8-1:0] w_strb;
        logic                  w_last;
        logic                  w_valid;
        logic                  b_ready;
        logic [IdW-1:0]        ar_id;
        logic [AddrW-1:0]      ar_addr;
        logic [7:0]            ar_len;
        logic [2:0]            ar_size;
        logic [1:0]            ar_burst;
        logic                  ar_valid;
        logic                  r_ready;
    } ctrl_req_t;

    typedef struct packed {
        logic                aw_ready;
        logic                w_ready;
        logic [IdW-1:0]      b_id;
        logic [1:0]          b_resp;
        logic                b_valid;
        logic                ar_ready;
        logic [IdW-1:0]      r_id;
        logic [AxiDataW-1:0] r_data;
        logic [1:0]          r_resp;
        logic                r_last;
        logic                r_valid;
    } ctrl_resp_t;

    function automatic logic [AddrW-1:0] next_beat_addr(input logic [AddrW-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
        return (burst == BurstIncr) ? addr + (AddrW'(1) << size) : addr;
    endfunction
endpackage

// File: rtl/ctrl_regfile.sv
// ctrl_regfile: control register decode, byte-strobe merge and read mux.
// CTRL_DECERR_EN makes unmapped offsets answer DECERR instead of OKAY.
module ctrl_regfile
    import ctrl_regs_pkg::*;
#(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned OffsetWidth = 12,
    parameter int unsigned NumCores    = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en,
    input  logic [OffsetWidth-1:0] wr_off,
    input  logic [DataWidth-1:0]   wr_data,
    input  logic [DataWidth/8-1:0] wr_strb,
    input  logic [OffsetWidth-1:0] rd_off,
    output logic [DataWidth-1:0]   rd_data,
    output logic [1:0]             wr_resp,
    output logic [1:0]             rd_resp,
    output logic [DataWidth-1:0]   eoc_o,
    output logic [DataWidth-1:0]   wake_up_o,
    output logic                   wake_up_valid_o
);
`ifdef CTRL_DECERR_EN
    localparam logic [1:0] UnmappedResp = RespDecErr;
`else
    localparam logic [1:0] UnmappedResp = RespOkay;
`endif
    localparam logic [OffsetWidth-1:0] OffEoc   = OffsetWidth'(EocOffset);
    localparam logic [OffsetWidth-1:0] OffWake  = OffsetWidth'(WakeUpOffset);
    localparam logic [OffsetWidth-1:0] OffScr0  = OffsetWidth'(Scratch0Offset);
    localparam logic [OffsetWidth-1:0] OffScr1  = OffsetWidth'(Scratch1Offset);
    localparam logic [OffsetWidth-1:0] OffCores = OffsetWidth'(NumCoresOffset);
    localparam logic [OffsetWidth-1:0] WordMask = ~OffsetWidth'(DataWidth/8-1);

    logic [DataWidth-1:0]   scratch0, scratch1;
    logic [OffsetWidth-1:0] wa, ra;

    assign wa = wr_off & WordMask;
    assign ra = rd_off & WordMask;

    function automatic logic [1:0] decode(input logic [OffsetWidth-1:0] off);
        return (off == OffEoc || off == OffWake || off == OffScr0 || off == OffScr1 || off == OffCores)
               ? RespOkay : UnmappedResp;
    endfunction

    function automatic logic [DataWidth-1:0] merge(input logic [DataWidth-1:0] old,
                                                   input logic [DataWidth-1:0] data,
                                                   input logic [DataWidth/8-1:0] strb);
        logic [DataWidth-1:0] r;
        r = old;
        for (int i = 0; i < DataWidth/8; i++)
            if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    assign wr_resp = decode(wa);
    assign rd_resp = decode(ra);
    assign rd_data = (ra == OffEoc)   ? eoc_o :
                     (ra == OffScr0)  ? scratch0 :
                     (ra == OffScr1)  ? scratch1 :
                     (ra == OffCores) ? DataWidth'(NumCores) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eoc_o           <= '0;
            scratch0        <= '0;
            scratch1        <= '0;
            wake_up_o       <= '0;
            wake_up_valid_o <= 1'b0;
        end else begin
            wake_up_valid_o <= wr_en && wa == OffWake;
            wake_up_o       <= (wr_en && wa == OffWake) ? wr_data : '0;
            if (wr_en && wa == OffEoc)  eoc_o    <= merge(eoc_o, wr_data, wr_strb);
            if (wr_en && wa == OffScr0) scratch0 <= merge(scratch0, wr_data, wr_strb);
            if (wr_en && wa == OffScr1) scratch1 <= merge(scratch1, wr_data, wr_strb);
        end
    end
endmodule

// File: rtl/axi_ctrl_responder.sv
// axi_ctrl_responder: AXI4 slave terminating the cluster control window, one beat at a time.
// Optional CTRL_DECERR_EN (in ctrl_regfile) returns DECERR for unmapped offsets.
module axi_ctrl_responder
    import ctrl_regs_pkg::*;
#(
    parameter int unsigned AxiIdWidth   = IdW,
    parameter int unsigned AxiAddrWidth = AddrW,
    parameter int unsigned AxiDataWidth = AxiDataW,
    parameter int unsigned DataWidth    = RegW,
    parameter int unsigned NumCores     = 256,
    parameter int unsigned OffsetWidth  = 12,
    parameter type         axi_req_t    = ctrl_req_t,
    parameter type         axi_resp_t   = ctrl_resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  axi_req_t             axi_req_i,
    output axi_resp_t            axi_resp_o,
    output logic [DataWidth-1:0] eoc_o,
    output logic                 eoc_valid_o,
    output logic [DataWidth-1:0] wake_up_o,
    output logic                 wake_up_valid_o
);
    localparam int unsigned NumLanes = AxiDataWidth / DataWidth;
    localparam int unsigned ByteBits = $clog2(DataWidth / 8);

    ctrl_state_e             state, state_d;
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr, nxt_addr, rd_addr;
    logic [7:0]              len, beat;
    logic [2:0]              size;
    logic [1:0]              burst, b_resp, r_resp, wr_resp, rd_resp, wr_resp_cur, rd_resp_cur;
    logic [AxiDataWidth-1:0] r_data, rd_place;
    logic [DataWidth-1:0]    rd_data;
    logic                    r_last, aw_hs, ar_hs, w_hs, r_hs, wr_en, w_done, rd_wrap;

    function automatic int lane_of(input logic [AxiAddrWidth-1:0] a);
        return int'((a >> ByteBits) % NumLanes);
    endfunction

    assign nxt_addr    = next_beat_addr(addr, size, burst);
    assign rd_addr     = (state == IDLE) ? axi_req_i.ar_addr : nxt_addr;
    assign rd_wrap     = ((state == IDLE) ? axi_req_i.ar_burst : burst) == BurstWrap;
    assign rd_place    = rd_wrap ? '0 : AxiDataWidth'(rd_data) << (lane_of(rd_addr) * DataWidth);
    assign rd_resp_cur = rd_wrap ? RespSlvErr : rd_resp;
    assign wr_resp_cur = (burst == BurstWrap) ? RespSlvErr : wr_resp;
    assign w_done      = axi_req_i.w_last || beat == len;
    assign aw_hs       = axi_resp_o.aw_ready && axi_req_i.aw_valid;
    assign ar_hs       = axi_resp_o.ar_ready && axi_req_i.ar_valid;
    assign w_hs        = axi_resp_o.w_ready && axi_req_i.w_valid;
    assign r_hs        = axi_resp_o.r_valid && axi_req_i.r_ready;
    assign wr_en       = w_hs && burst != BurstWrap;
    assign eoc_valid_o = eoc_o[0];

    ctrl_regfile #(
        .DataWidth  (DataWidth),
        .OffsetWidth(OffsetWidth),
        .NumCores   (NumCores)
    ) i_regfile (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wr_en          (wr_en),
        .wr_off         (addr[OffsetWidth-1:0]),
        .wr_data        (axi_req_i.w_data[lane_of(addr)*DataWidth +: DataWidth]),
        .wr_strb        (axi_req_i.w_strb[lane_of(addr)*(DataWidth/8) +: DataWidth/8]),
        .rd_off         (rd_addr[OffsetWidth-1:0]),
        .rd_data        (rd_data),
        .wr_resp        (wr_resp),
        .rd_resp        (rd_resp),
        .eoc_o          (eoc_o),
        .wake_up_o      (wake_up_o),
        .wake_up_valid_o(wake_up_valid_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_d;
    end

    // Write wins a simultaneous AW/AR; ready only follows a pending valid.
    always_comb begin
        state_d           = state;
        axi_resp_o        = '0;
        axi_resp_o.b_id   = id;
        axi_resp_o.b_resp = b_resp;
        axi_resp_o.r_id   = id;
        axi_resp_o.r_data = r_data;
        axi_resp_o.r_resp = r_resp;
        axi_resp_o.r_last = r_last;
        case (state)
            IDLE: begin
                axi_resp_o.aw_ready = axi_req_i.aw_valid;
                axi_resp_o.ar_ready = axi_req_i.ar_valid && !axi_req_i.aw_valid;
                state_d = axi_req_i.aw_valid ? WRITE : axi_req_i.ar_valid ? READ : IDLE;
            end
            WRITE: begin
                axi_resp_o.w_ready = 1'b1;
                state_d = (axi_req_i.w_valid && w_done) ? WRITE_RESP : WRITE;
            end
            WRITE_RESP: begin
                axi_resp_o.b_valid = 1'b1;
                state_d = axi_req_i.b_ready ? IDLE : WRITE_RESP;
            end
            READ: begin
                axi_resp_o.r_valid = 1'b1;
                state_d = (axi_req_i.r_ready && r_last) ? IDLE : READ;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id     <= '0;
            addr   <= '0;
            len    <= '0;
            size   <= '0;
            burst  <= '0;
            beat   <= '0;
            b_resp <= RespOkay;
            r_data <= '0;
            r_resp <= RespOkay;
            r_last <= 1'b0;
        end else if (aw_hs) begin
            id     <= axi_req_i.aw_id;
            addr   <= axi_req_i.aw_addr;
            len    <= axi_req_i.aw_len;
            size   <= axi_req_i.aw_size;
            burst  <= axi_req_i.aw_burst;
            beat   <= '0;
            b_resp <= RespOkay;
        end else if (ar_hs) begin
            id     <= axi_req_i.ar_id;
            addr   <= axi_req_i.ar_addr;
            len    <= axi_req_i.ar_len;
            size   <= axi_req_i.ar_size;
            burst  <= axi_req_i.ar_burst;
            beat   <= '0;
            r_data <= rd_place;
            r_resp <= rd_resp_cur;
            r_last <= axi_req_i.ar_len == 8'd0;
        end else if (w_hs) begin
            addr   <= nxt_addr;
            beat   <= beat + 8'd1;
            b_resp <= (wr_resp_cur > b_resp) ? wr_resp_cur : b_resp;
        end else if (r_hs && !r_last) begin
            addr   <= nxt_addr;
            beat   <= beat + 8'd1;
            r_data <= rd_place;
            r_resp <= rd_resp_cur;
            r_last <= beat + 8'd1 == len;
        end
    end
endmodule
